// File: rtl/divisor_8bits_sequencial.sv
// Restoring 8-bit unsigned divider: one quotient bit per clock, done pulses 9 edges after start.
// Optional DIV_ZERO_DETECT_EN: b=0 short-circuits to q=FF, r=a with div_zero one edge after start.
module divisor_8bits_sequencial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] q,
    output logic [7:0] r,
    output logic       busy,
    output logic       done
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic       div_zero
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DZERO = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_rem;
    logic [7:0] r_qw;
    logic [2:0] r_k;
    logic [7:0] r_q;
    logic [7:0] r_r;
    logic       r_busy;
    logic       r_done;

    logic [8:0] w_t;
    logic [8:0] w_sub;
    logic       w_ge;
    logic [7:0] w_rem_nxt;
    logic [7:0] w_qw_nxt;

    // 9-bit compare: the shifted-in partial remainder can exceed 255.
    always_comb begin
        w_t       = {r_rem, r_a[r_k]};
        w_ge      = (w_t >= {1'b0, r_b});
        w_sub     = w_t - {1'b0, r_b};
        w_rem_nxt = w_ge ? w_sub[7:0] : w_t[7:0];
        w_qw_nxt  = r_qw;
        w_qw_nxt[r_k] = w_ge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_DETECT_EN
                    w_state_nxt = (b == 8'd0) ? S_DZERO : S_RUN;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (r_k == 3'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DZERO: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef DIV_ZERO_DETECT_EN
    logic r_dz;
    assign div_zero = r_dz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dz <= 1'b0;
        end else if (r_state == S_DZERO) begin
            r_dz <= 1'b1;
        end else if (r_state == S_RUN && r_k == 3'd0) begin
            r_dz <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= 8'h00;
            r_b    <= 8'h00;
            r_rem  <= 8'h00;
            r_qw   <= 8'h00;
            r_k    <= 3'd7;
            r_q    <= 8'h00;
            r_r    <= 8'h00;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_nxt == S_RUN);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_rem <= 8'h00;
                        r_qw  <= 8'h00;
                        r_k   <= 3'd7;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_qw  <= w_qw_nxt;
                    r_k   <= r_k - 3'd1;
                    if (r_k == 3'd0) begin
                        r_q    <= w_qw_nxt;
                        r_r    <= w_rem_nxt;
                        r_done <= 1'b1;
                    end
                end
                S_DZERO: begin
                    r_q    <= 8'hFF;
                    r_r    <= r_a;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign q    = r_q;
    assign r    = r_r;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_divisor_8bits_sequencial.sv
// Directed checks of the sequential divider: reset, vectors, busy window, start-ignore, reset abort, random sweep.
module tb_divisor_8bits_sequencial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divisor_8bits_sequencial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done)
    );

    // Launch one operation and wait (bounded) for done; lat=99 means it never came.
    task automatic do_div(input logic [7:0] av, input logic [7:0] bv,
                          output logic [7:0] qv, output logic [7:0] rv, output int lat);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        qv = q;
        rv = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_r got %h want 00", r); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nbusy = 0;
        int lat = 99;
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
        checks++; if (nbusy != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", nbusy); end
        checks++; if (q !== 8'd28) begin errors++; $display("FAIL basic_q got %0d want 28", q); end
        checks++; if (r !== 8'd4) begin errors++; $display("FAIL basic_r got %0d want 4", r); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
        checks++; if (q !== 8'd28) begin errors++; $display("FAIL basic_q_hold got %0d want 28", q); end
    endtask

    task automatic test_vectors();
        logic [7:0] tv_a [8] = '{8'd255, 8'd5, 8'd0,   8'd100, 8'd128, 8'd254, 8'd255, 8'd0};
        logic [7:0] tv_b [8] = '{8'd1,   8'd9, 8'd255, 8'd0,   8'd128, 8'd255, 8'd16,  8'd0};
        logic [7:0] tv_q [8] = '{8'd255, 8'd0, 8'd0,   8'hFF,  8'd1,   8'd0,   8'd15,  8'hFF};
        logic [7:0] tv_r [8] = '{8'd0,   8'd5, 8'd0,   8'd100, 8'd0,   8'd254, 8'd15,  8'd0};
        logic [7:0] qv, rv;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_div(tv_a[i], tv_b[i], qv, rv, lat);
            checks++; if (lat != 9) begin errors++; $display("FAIL vec%0d_latency got %0d want 9", i, lat); end
            checks++; if (qv !== tv_q[i]) begin errors++; $display("FAIL vec%0d_q %0d/%0d got %0d want %0d", i, tv_a[i], tv_b[i], qv, tv_q[i]); end
            checks++; if (rv !== tv_r[i]) begin errors++; $display("FAIL vec%0d_r %0d/%0d got %0d want %0d", i, tv_a[i], tv_b[i], rv, tv_r[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat = 99;
        int lat2 = 99;
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            // a start sampled at E3 while busy must be dropped; inputs also wander mid-run
            if (i == 2) begin start = 1'b1; a = 8'd9; b = 8'd3; end
            if (i == 3) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL ignore_latency got %0d want 9", lat); end
        checks++; if (q !== 8'd28) begin errors++; $display("FAIL ignore_q got %0d want 28", q); end
        checks++; if (r !== 8'd4) begin errors++; $display("FAIL ignore_r got %0d want 4", r); end
        start = 1'b1; a = 8'd9; b = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4) begin
                checks++; if (q !== 8'd28) begin errors++; $display("FAIL b2b_q_hold got %0d want 28", q); end
            end
            if (done) begin
                lat2 = i;
                break;
            end
        end
        checks++; if (lat2 != 9) begin errors++; $display("FAIL b2b_latency got %0d want 9", lat2); end
        checks++; if (q !== 8'd3) begin errors++; $display("FAIL b2b_q got %0d want 3", q); end
        checks++; if (r !== 8'd0) begin errors++; $display("FAIL b2b_r got %0d want 0", r); end
    endtask

    task automatic test_reset_midrun();
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL abort_q got %0d want 0", q); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL abort_r got %0d want 0", r); end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", ndone); end
    endtask

    task automatic test_sweep();
        logic [7:0] av, bv, qv, rv, eq, er;
        int lat;
        for (int n = 0; n < 400; n++) begin
            av = 8'($urandom_range(0, 255));
            bv = (n % 50 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            do_div(av, bv, qv, rv, lat);
            eq = (bv == 8'd0) ? 8'hFF : av / bv;
            er = (bv == 8'd0) ? av : av % bv;
            checks++;
            if (lat != 9 || qv !== eq || rv !== er) begin
                errors++;
                $display("FAIL sweep %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=9", av, bv, qv, rv, lat, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_reset_midrun();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
